// File: rtl/axi4lite_arb2.sv
// Two-requester AXI4-Lite arbiter onto one shared slave. Read and write paths
// each run their own FSM with qos-first, round-robin-on-tie granting.
module axi4lite_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 1,
  parameter int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [ADDR_WIDTH-1:0] m0_ar_addr,
  input  logic [3:0]            m0_ar_qos,
  input  logic                  m0_ar_valid,
  output logic                  m0_ar_ready,
  output logic [DATA_WIDTH-1:0] m0_r_data,
  output logic [RESP_WIDTH-1:0] m0_r_resp,
  output logic                  m0_r_valid,
  input  logic                  m0_r_ready,
  input  logic [ADDR_WIDTH-1:0] m0_aw_addr,
  input  logic [3:0]            m0_aw_qos,
  input  logic                  m0_aw_valid,
  output logic                  m0_aw_ready,
  input  logic [DATA_WIDTH-1:0] m0_w_data,
  input  logic [STRB_WIDTH-1:0] m0_w_strb,
  input  logic                  m0_w_valid,
  output logic                  m0_w_ready,
  output logic [RESP_WIDTH-1:0] m0_b_resp,
  output logic                  m0_b_valid,
  input  logic                  m0_b_ready,

  input  logic [ADDR_WIDTH-1:0] m1_ar_addr,
  input  logic [3:0]            m1_ar_qos,
  input  logic                  m1_ar_valid,
  output logic                  m1_ar_ready,
  output logic [DATA_WIDTH-1:0] m1_r_data,
  output logic [RESP_WIDTH-1:0] m1_r_resp,
  output logic                  m1_r_valid,
  input  logic                  m1_r_ready,
  input  logic [ADDR_WIDTH-1:0] m1_aw_addr,
  input  logic [3:0]            m1_aw_qos,
  input  logic                  m1_aw_valid,
  output logic                  m1_aw_ready,
  input  logic [DATA_WIDTH-1:0] m1_w_data,
  input  logic [STRB_WIDTH-1:0] m1_w_strb,
  input  logic                  m1_w_valid,
  output logic                  m1_w_ready,
  output logic [RESP_WIDTH-1:0] m1_b_resp,
  output logic                  m1_b_valid,
  input  logic                  m1_b_ready,

  output logic [ADDR_WIDTH-1:0] s_ar_addr,
  output logic                  s_ar_valid,
  input  logic                  s_ar_ready,
  input  logic [DATA_WIDTH-1:0] s_r_data,
  input  logic [RESP_WIDTH-1:0] s_r_resp,
  input  logic                  s_r_valid,
  output logic                  s_r_ready,
  output logic [ADDR_WIDTH-1:0] s_aw_addr,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [DATA_WIDTH-1:0] s_w_data,
  output logic [STRB_WIDTH-1:0] s_w_strb,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  input  logic [RESP_WIDTH-1:0] s_b_resp,
  input  logic                  s_b_valid,
  output logic                  s_b_ready
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  // Returns the winning index: higher qos wins, a tie goes to the requester
  // that was not granted last on this path.
  function automatic logic pick(input logic v0, input logic v1,
                                input logic [3:0] q0, input logic [3:0] q1,
                                input logic last);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    if (q0 > q1)   return 1'b0;
    if (q1 > q0)   return 1'b1;
    return ~last;
  endfunction

  wstate_t wstate;
  rstate_t rstate;
  logic    wgnt, wrr, aw_done, w_done;
  logic    rgnt, rrr;

  logic w_req, w_pick, r_req, r_pick;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic w_xfer, w_resp, r_addr, r_data;

  assign w_req  = m0_aw_valid | m1_aw_valid;
  assign w_pick = pick(m0_aw_valid, m1_aw_valid, m0_aw_qos, m1_aw_qos, wrr);
  assign r_req  = m0_ar_valid | m1_ar_valid;
  assign r_pick = pick(m0_ar_valid, m1_ar_valid, m0_ar_qos, m1_ar_qos, rrr);

  assign aw_hs = s_aw_valid & s_aw_ready;
  assign w_hs  = s_w_valid & s_w_ready;
  assign b_hs  = s_b_valid & s_b_ready;
  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs  = s_r_valid & s_r_ready;

  // Reset forces every valid/ready low even before the state has been cleared.
  assign w_xfer = (wstate == W_XFER) && !rst_i;
  assign w_resp = (wstate == W_RESP) && !rst_i;
  assign r_addr = (rstate == R_ADDR) && !rst_i;
  assign r_data = (rstate == R_DATA) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate  <= W_IDLE;
      wgnt    <= 1'b0;
      wrr     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (w_req) begin
            wgnt    <= w_pick;
            wrr     <= w_pick;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= W_XFER;
          end
        end
        W_XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) wstate <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate <= R_IDLE;
      rgnt   <= 1'b0;
      rrr    <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (r_req) begin
            rgnt   <= r_pick;
            rrr    <= r_pick;
            rstate <= R_ADDR;
          end
        end
        R_ADDR:  if (ar_hs) rstate <= R_DATA;
        R_DATA:  if (r_hs)  rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write path routing: request channels follow the grant, responses only reach the grantee.
  always_comb begin
    s_aw_addr   = wgnt ? m1_aw_addr : m0_aw_addr;
    s_aw_valid  = w_xfer && !aw_done && (wgnt ? m1_aw_valid : m0_aw_valid);
    s_w_data    = wgnt ? m1_w_data : m0_w_data;
    s_w_strb    = wgnt ? m1_w_strb : m0_w_strb;
    s_w_valid   = w_xfer && !w_done && (wgnt ? m1_w_valid : m0_w_valid);
    m0_aw_ready = w_xfer && !aw_done && !wgnt && s_aw_ready;
    m1_aw_ready = w_xfer && !aw_done &&  wgnt && s_aw_ready;
    m0_w_ready  = w_xfer && !w_done && !wgnt && s_w_ready;
    m1_w_ready  = w_xfer && !w_done &&  wgnt && s_w_ready;
    s_b_ready   = w_resp && (wgnt ? m1_b_ready : m0_b_ready);
    m0_b_valid  = w_resp && !wgnt && s_b_valid;
    m1_b_valid  = w_resp &&  wgnt && s_b_valid;
    m0_b_resp   = wgnt ? '0 : s_b_resp;
    m1_b_resp   = wgnt ? s_b_resp : '0;
  end

  // Read path routing mirrors the write path.
  always_comb begin
    s_ar_addr   = rgnt ? m1_ar_addr : m0_ar_addr;
    s_ar_valid  = r_addr && (rgnt ? m1_ar_valid : m0_ar_valid);
    m0_ar_ready = r_addr && !rgnt && s_ar_ready;
    m1_ar_ready = r_addr &&  rgnt && s_ar_ready;
    s_r_ready   = r_data && (rgnt ? m1_r_ready : m0_r_ready);
    m0_r_valid  = r_data && !rgnt && s_r_valid;
    m1_r_valid  = r_data &&  rgnt && s_r_valid;
    m0_r_data   = rgnt ? '0 : s_r_data;
    m1_r_data   = rgnt ? s_r_data : '0;
    m0_r_resp   = rgnt ? '0 : s_r_resp;
    m1_r_resp   = rgnt ? s_r_resp : '0;
  end

endmodule

// File: tb/tb_axi4lite_arb2.sv
// Directed bench for axi4lite_arb2: the bench plays both requesters and the slave.
module tb_axi4lite_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_ar_addr, m1_ar_addr, m0_aw_addr, m1_aw_addr;
  logic [3:0]  m0_ar_qos, m1_ar_qos, m0_aw_qos, m1_aw_qos;
  logic        m0_ar_valid, m1_ar_valid, m0_ar_ready, m1_ar_ready;
  logic [31:0] m0_r_data, m1_r_data;
  logic        m0_r_resp, m1_r_resp, m0_r_valid, m1_r_valid, m0_r_ready, m1_r_ready;
  logic        m0_aw_valid, m1_aw_valid, m0_aw_ready, m1_aw_ready;
  logic [31:0] m0_w_data, m1_w_data;
  logic [3:0]  m0_w_strb, m1_w_strb;
  logic        m0_w_valid, m1_w_valid, m0_w_ready, m1_w_ready;
  logic        m0_b_resp, m1_b_resp, m0_b_valid, m1_b_valid, m0_b_ready, m1_b_ready;
  logic [31:0] s_ar_addr, s_aw_addr, s_r_data, s_w_data;
  logic        s_ar_valid, s_ar_ready, s_r_resp, s_r_valid, s_r_ready;
  logic        s_aw_valid, s_aw_ready;
  logic [3:0]  s_w_strb;
  logic        s_w_valid, s_w_ready, s_b_resp, s_b_valid, s_b_ready;

  int checks = 0;
  int errors = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_aw_valid && s_aw_ready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (s_w_valid && s_w_ready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  axi4lite_arb2 dut (
    .clk_i(clk), .rst_i(rst),
    .m0_ar_addr(m0_ar_addr), .m0_ar_qos(m0_ar_qos), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m0_aw_addr(m0_aw_addr), .m0_aw_qos(m0_aw_qos), .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
    .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
    .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
    .m1_ar_addr(m1_ar_addr), .m1_ar_qos(m1_ar_qos), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .m1_aw_addr(m1_aw_addr), .m1_aw_qos(m1_aw_qos), .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
    .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
    .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_ar_addr = '0; m0_ar_qos = '0; m0_ar_valid = 0; m0_r_ready = 0;
    m0_aw_addr = '0; m0_aw_qos = '0; m0_aw_valid = 0; m0_w_data = '0;
    m0_w_strb = 4'hf; m0_w_valid = 0; m0_b_ready = 0;
    m1_ar_addr = '0; m1_ar_qos = '0; m1_ar_valid = 0; m1_r_ready = 0;
    m1_aw_addr = '0; m1_aw_qos = '0; m1_aw_valid = 0; m1_w_data = '0;
    m1_w_strb = 4'hf; m1_w_valid = 0; m1_b_ready = 0;
    s_ar_ready = 0; s_r_data = '0; s_r_resp = 0; s_r_valid = 0;
    s_aw_ready = 0; s_w_ready = 0; s_b_resp = 0; s_b_valid = 0;
  endtask

  // Slave side of an already granted write: accept AW+W, then answer B.
  task automatic finish_write(input int who);
    s_aw_ready = 1; s_w_ready = 1;
    step();
    if (who == 0) begin m0_aw_valid = 0; m0_w_valid = 0; m0_b_ready = 1; end
    else          begin m1_aw_valid = 0; m1_w_valid = 0; m1_b_ready = 1; end
    s_aw_ready = 0; s_w_ready = 0; s_b_valid = 1;
    step();
    s_b_valid = 0; m0_b_ready = 0; m1_b_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    m0_aw_valid = 1; m1_ar_valid = 1; s_b_valid = 1; s_r_valid = 1;
    s_aw_ready = 1; s_ar_ready = 1; m0_b_ready = 1; m1_r_ready = 1;
    step(); step();
    checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL reset_s_aw_valid: got %0b want 0", s_aw_valid); end
    checks++; if (s_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_s_ar_valid: got %0b want 0", s_ar_valid); end
    checks++; if (m0_b_valid !== 1'b0) begin errors++; $display("FAIL reset_m0_b_valid: got %0b want 0", m0_b_valid); end
    checks++; if (m1_r_valid !== 1'b0) begin errors++; $display("FAIL reset_m1_r_valid: got %0b want 0", m1_r_valid); end
    checks++; if (m0_aw_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_aw_ready: got %0b want 0", m0_aw_ready); end
    checks++; if (s_b_ready !== 1'b0) begin errors++; $display("FAIL reset_s_b_ready: got %0b want 0", s_b_ready); end
    rst = 0;
    clear_inputs();
    step();
    checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_s_w_valid: got %0b want 0", s_w_valid); end
  endtask

  task automatic test_qos();
    m0_aw_valid = 1; m0_aw_qos = 4'd2; m0_aw_addr = 32'h20; m0_w_valid = 1; m0_w_data = 32'h11111111;
    m1_aw_valid = 1; m1_aw_qos = 4'd5; m1_aw_addr = 32'h10; m1_w_valid = 1; m1_w_data = 32'hDEADBEEF;
    settle();
    checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL qos_idle_no_fwd: got %0b want 0", s_aw_valid); end
    step();
    checks++; if (s_aw_valid !== 1'b1) begin errors++; $display("FAIL qos_s_aw_valid: got %0b want 1", s_aw_valid); end
    checks++; if (s_aw_addr !== 32'h10) begin errors++; $display("FAIL qos_s_aw_addr: got %0h want 10", s_aw_addr); end
    checks++; if (s_w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL qos_s_w_data: got %0h want deadbeef", s_w_data); end
    s_aw_ready = 1; s_w_ready = 1;
    settle();
    checks++; if (m1_aw_ready !== 1'b1) begin errors++; $display("FAIL qos_m1_aw_ready: got %0b want 1", m1_aw_ready); end
    checks++; if (m0_aw_ready !== 1'b0) begin errors++; $display("FAIL qos_m0_aw_ready_xfer: got %0b want 0", m0_aw_ready); end
    step();
    m1_aw_valid = 0; m1_w_valid = 0; s_w_ready = 0; s_b_valid = 1; s_b_resp = 1;
    settle();
    checks++; if (m1_b_valid !== 1'b1) begin errors++; $display("FAIL qos_m1_b_valid: got %0b want 1", m1_b_valid); end
    checks++; if (m1_b_resp !== 1'b1) begin errors++; $display("FAIL qos_m1_b_resp: got %0b want 1", m1_b_resp); end
    checks++; if (m0_b_valid !== 1'b0) begin errors++; $display("FAIL qos_m0_b_valid: got %0b want 0", m0_b_valid); end
    checks++; if (m0_aw_ready !== 1'b0) begin errors++; $display("FAIL qos_m0_aw_ready_resp: got %0b want 0", m0_aw_ready); end
    m1_b_ready = 1;
    settle();
    checks++; if (s_b_ready !== 1'b1) begin errors++; $display("FAIL qos_s_b_ready: got %0b want 1", s_b_ready); end
    step();
    s_b_valid = 0; s_b_resp = 0; m1_b_ready = 0; s_aw_ready = 0;
    settle();
    checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL qos_reidle: got %0b want 0", s_aw_valid); end
    step();
    checks++; if (s_aw_addr !== 32'h20) begin errors++; $display("FAIL qos_m0_next_addr: got %0h want 20", s_aw_addr); end
    finish_write(0);
  endtask

  task automatic test_round_robin();
    logic exp_m1;
    m0_aw_valid = 1; m0_aw_qos = 4'd3; m0_aw_addr = 32'h100; m0_w_valid = 1;
    m1_aw_valid = 1; m1_aw_qos = 4'd3; m1_aw_addr = 32'h200; m1_w_valid = 1;
    for (int i = 0; i < 4; i++) begin
      exp_m1 = (i % 2 == 0);
      step();
      checks++;
      if (s_aw_addr !== (exp_m1 ? 32'h200 : 32'h100)) begin
        errors++; $display("FAIL rr_grant_%0d: got %0h want %0h", i, s_aw_addr, exp_m1 ? 32'h200 : 32'h100);
      end
      s_aw_ready = 1; s_w_ready = 1;
      settle();
      checks++;
      if ((exp_m1 ? m0_aw_ready : m1_aw_ready) !== 1'b0) begin
        errors++; $display("FAIL rr_loser_ready_%0d: got 1 want 0", i);
      end
      step();
      s_aw_ready = 0; s_w_ready = 0; s_b_valid = 1; m0_b_ready = 1; m1_b_ready = 1;
      step();
      s_b_valid = 0; m0_b_ready = 0; m1_b_ready = 0;
    end
    m0_aw_valid = 0; m0_w_valid = 0; m1_aw_valid = 0; m1_w_valid = 0;
    step();
  endtask

  task automatic test_w_first();
    int a0, w0;
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    m0_aw_valid = 1; m0_aw_addr = 32'h30; m0_w_valid = 1; m0_w_data = 32'h12345678;
    step();
    s_w_ready = 1;
    settle();
    checks++; if (m0_w_ready !== 1'b1) begin errors++; $display("FAIL wfirst_m0_w_ready: got %0b want 1", m0_w_ready); end
    step();
    checks++; if (s_w_valid !== 1'b0) begin errors++; $display("FAIL wfirst_w_valid_drop: got %0b want 0", s_w_valid); end
    checks++; if (s_aw_valid !== 1'b1) begin errors++; $display("FAIL wfirst_aw_pending: got %0b want 1", s_aw_valid); end
    step();
    s_aw_ready = 1;
    settle();
    checks++; if (m0_aw_ready !== 1'b1) begin errors++; $display("FAIL wfirst_m0_aw_ready: got %0b want 1", m0_aw_ready); end
    step();
    m0_aw_valid = 0; m0_w_valid = 0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 1;
    settle();
    checks++; if (m0_b_valid !== 1'b1) begin errors++; $display("FAIL wfirst_in_resp: got %0b want 1", m0_b_valid); end
    checks++; if (aw_hs_cnt - a0 !== 1) begin errors++; $display("FAIL wfirst_aw_count: got %0d want 1", aw_hs_cnt - a0); end
    checks++; if (w_hs_cnt - w0 !== 1) begin errors++; $display("FAIL wfirst_w_count: got %0d want 1", w_hs_cnt - w0); end
    m0_b_ready = 1;
    step();
    s_b_valid = 0; m0_b_ready = 0;
  endtask

  task automatic test_concurrent();
    m0_ar_valid = 1; m0_ar_addr = 32'h04;
    m1_aw_valid = 1; m1_aw_addr = 32'h08; m1_w_valid = 1; m1_w_data = 32'hCAFEF00D;
    step();
    checks++; if (s_ar_addr !== 32'h04 || s_ar_valid !== 1'b1) begin errors++; $display("FAIL conc_ar: got %0h/%0b want 4/1", s_ar_addr, s_ar_valid); end
    checks++; if (s_aw_addr !== 32'h08 || s_aw_valid !== 1'b1) begin errors++; $display("FAIL conc_aw: got %0h/%0b want 8/1", s_aw_addr, s_aw_valid); end
    s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
    step();
    m0_ar_valid = 0; m1_aw_valid = 0; m1_w_valid = 0;
    s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
    s_r_valid = 1; s_r_data = 32'hA5A5A5A5; s_b_valid = 1; s_b_resp = 1;
    m0_r_ready = 1; m1_b_ready = 1;
    settle();
    checks++; if (m0_r_valid !== 1'b1 || m0_r_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL conc_m0_r: got %0b/%0h want 1/a5a5a5a5", m0_r_valid, m0_r_data); end
    checks++; if (m1_r_valid !== 1'b0) begin errors++; $display("FAIL conc_m1_r_valid: got %0b want 0", m1_r_valid); end
    checks++; if (m1_b_valid !== 1'b1 || m1_b_resp !== 1'b1) begin errors++; $display("FAIL conc_m1_b: got %0b/%0b want 1/1", m1_b_valid, m1_b_resp); end
    checks++; if (m0_b_valid !== 1'b0) begin errors++; $display("FAIL conc_m0_b_valid: got %0b want 0", m0_b_valid); end
    checks++; if (s_r_ready !== 1'b1 || s_b_ready !== 1'b1) begin errors++; $display("FAIL conc_readies: got %0b/%0b want 1/1", s_r_ready, s_b_ready); end
    step();
    s_r_valid = 0; s_b_valid = 0; s_b_resp = 0; m0_r_ready = 0; m1_b_ready = 0;
    step();
  endtask

  task automatic test_read_qos();
    m0_ar_valid = 1; m0_ar_qos = 4'd1; m0_ar_addr = 32'h40;
    m1_ar_valid = 1; m1_ar_qos = 4'd9; m1_ar_addr = 32'h44;
    step();
    s_ar_ready = 1;
    settle();
    checks++; if (s_ar_addr !== 32'h44) begin errors++; $display("FAIL rqos_addr: got %0h want 44", s_ar_addr); end
    checks++; if (m0_ar_ready !== 1'b0 || m1_ar_ready !== 1'b1) begin errors++; $display("FAIL rqos_readies: got %0b/%0b want 0/1", m0_ar_ready, m1_ar_ready); end
    step();
    m1_ar_valid = 0; s_ar_ready = 0; s_r_valid = 1; s_r_data = 32'h5555AAAA; s_r_resp = 1; m1_r_ready = 1;
    settle();
    checks++; if (m1_r_data !== 32'h5555AAAA || m1_r_resp !== 1'b1) begin errors++; $display("FAIL rqos_m1_r: got %0h/%0b want 5555aaaa/1", m1_r_data, m1_r_resp); end
    checks++; if (m0_r_valid !== 1'b0) begin errors++; $display("FAIL rqos_m0_r_valid: got %0b want 0", m0_r_valid); end
    step();
    s_r_valid = 0; s_r_resp = 0; m1_r_ready = 0;
    step();
    checks++; if (s_ar_addr !== 32'h40 || s_ar_valid !== 1'b1) begin errors++; $display("FAIL rqos_m0_next: got %0h/%0b want 40/1", s_ar_addr, s_ar_valid); end
    s_ar_ready = 1;
    step();
    m0_ar_valid = 0; s_ar_ready = 0; s_r_valid = 1; m0_r_ready = 1;
    step();
    s_r_valid = 0; m0_r_ready = 0;
  endtask

  task automatic test_reset_in_resp();
    m1_aw_valid = 1; m1_aw_addr = 32'h50; m1_w_valid = 1;
    step();
    s_aw_ready = 1; s_w_ready = 1;
    step();
    m1_aw_valid = 0; m1_w_valid = 0; s_aw_ready = 0; s_w_ready = 0; s_b_valid = 1; m1_b_ready = 1;
    rst = 1;
    settle();
    checks++; if (m1_b_valid !== 1'b0 || s_b_ready !== 1'b0) begin errors++; $display("FAIL rstresp_during: got %0b/%0b want 0/0", m1_b_valid, s_b_ready); end
    step();
    rst = 0;
    settle();
    checks++; if (m1_b_valid !== 1'b0 || s_b_ready !== 1'b0) begin errors++; $display("FAIL rstresp_after: got %0b/%0b want 0/0", m1_b_valid, s_b_ready); end
    s_b_valid = 0; m1_b_ready = 0;
    m0_aw_valid = 1; m0_aw_qos = 4'd3; m0_aw_addr = 32'h60; m0_w_valid = 1;
    m1_aw_valid = 1; m1_aw_qos = 4'd3; m1_aw_addr = 32'h64; m1_w_valid = 1;
    settle();
    checks++; if (s_aw_valid !== 1'b0) begin errors++; $display("FAIL rstresp_idle: got %0b want 0", s_aw_valid); end
    step();
    checks++; if (s_aw_addr !== 32'h64) begin errors++; $display("FAIL rstresp_tie_m1: got %0h want 64", s_aw_addr); end
    finish_write(1);
    m0_aw_valid = 0; m0_w_valid = 0;
    step();
  endtask

  task automatic test_b_stall();
    m0_aw_valid = 1; m0_aw_qos = 4'd3; m0_aw_addr = 32'h70; m0_w_valid = 1;
    m1_aw_valid = 1; m1_aw_qos = 4'd3; m1_aw_addr = 32'h74; m1_w_valid = 1;
    step();
    checks++; if (s_aw_addr !== 32'h70) begin errors++; $display("FAIL stall_grant_m0: got %0h want 70", s_aw_addr); end
    m1_aw_qos = 4'd15; m1_aw_addr = 32'h78;
    settle();
    checks++; if (s_aw_addr !== 32'h70) begin errors++; $display("FAIL stall_loser_change: got %0h want 70", s_aw_addr); end
    s_aw_ready = 1; s_w_ready = 1;
    step();
    m0_aw_valid = 0; m0_w_valid = 0; s_w_ready = 0; s_b_valid = 1; m0_b_ready = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (m0_b_valid !== 1'b1 || s_b_ready !== 1'b0 || s_aw_valid !== 1'b0 || m1_aw_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got b_valid=%0b b_ready=%0b aw_valid=%0b m1_aw_ready=%0b want 1 0 0 0",
                 k, m0_b_valid, s_b_ready, s_aw_valid, m1_aw_ready);
      end
      step();
    end
    s_aw_ready = 0;
    m0_b_ready = 1;
    settle();
    checks++; if (s_b_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b want 1", s_b_ready); end
    step();
    s_b_valid = 0; m0_b_ready = 0;
    step();
    checks++; if (s_aw_addr !== 32'h78 || s_aw_valid !== 1'b1) begin errors++; $display("FAIL stall_m1_served: got %0h/%0b want 78/1", s_aw_addr, s_aw_valid); end
    finish_write(1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_qos();
    test_round_robin();
    test_w_first();
    test_concurrent();
    test_read_qos();
    test_reset_in_resp();
    test_b_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_arb2.md
AXI4LITE_ARB2 -- requirements
Module: axi4lite_arb2

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AR/AW channels.
REQ-002 Parameter DATA_WIDTH, default 32, width of all R/W data; STRB_WIDTH = (DATA_WIDTH+7)/8.
REQ-003 Parameter RESP_WIDTH, default 1, width of all r_resp/b_resp.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 mN_ar_addr/ar_qos[3:0]/ar_valid  in, mN_ar_ready  out  (N=0,1)  requester N read address channel.
REQ-007 mN_r_data/r_resp/r_valid  out, mN_r_ready  in  requester N read data channel.
REQ-008 mN_aw_addr/aw_qos[3:0]/aw_valid  in, mN_aw_ready  out  requester N write address channel.
REQ-009 mN_w_data/w_strb/w_valid  in, mN_w_ready  out  requester N write data channel.
REQ-010 mN_b_resp/b_valid  out, mN_b_ready  in  requester N write response channel.
REQ-011 s_ar_*, s_aw_*, s_w_* out (valid/payload), s_*_ready in; s_r_*, s_b_* in, s_r_ready/s_b_ready out  shared downstream AXI4-Lite slave, same widths.

Function
REQ-012 Read and write paths SHALL be arbitrated independently, each with at most one outstanding transaction.
REQ-013 Write FSM states SHALL be W_IDLE, W_XFER, W_RESP; read FSM states SHALL be R_IDLE, R_ADDR, R_DATA.
REQ-014 In W_IDLE with any mN_aw_valid=1, FSM SHALL latch grant wgnt and go to W_XFER next cycle; no AW forwarded in W_IDLE.
REQ-015 Grant rule: higher aw_qos wins; equal qos -> requester not granted last on that path (round-robin pointer); single requester always wins.
REQ-016 In W_XFER, s_aw_*/s_w_* SHALL mirror granted requester combinationally; granted aw_ready/w_ready = s_aw_ready/s_w_ready; loser's readies = 0.
REQ-017 AW and W handshakes may complete in either order or same cycle; each SHALL be tracked by a done flag that gates its valid low after handshake; W_XFER -> W_RESP when both done.
REQ-018 In W_RESP, s_b_* SHALL route to granted requester, s_b_ready = granted mN_b_ready; on s_b_valid&&s_b_ready -> W_IDLE, done flags cleared.
REQ-019 Read FSM SHALL mirror REQ-014..018 with ar_qos, rgnt, R_ADDR forwarding AR, R_DATA routing R; on r handshake -> R_IDLE.
REQ-020 Non-granted requester's b_valid/r_valid SHALL be 0 at all times.
REQ-021 Round-robin pointer per path SHALL update to the granted index at grant time.
REQ-022 Requester qos/addr changes while not granted SHALL NOT affect the current transaction.
REQ-023 Minimum write turnaround: request cycle N, s_aw_valid at N+1; back-to-back grant possible in cycle after IDLE re-entry.
REQ-024 Response payload (resp, data) SHALL pass unmodified; no error generation.

Reset
REQ-025 On rst_i=1 at a clock edge both FSMs SHALL enter IDLE, done flags cleared, both RR pointers = 0 (m1 favoured on first tie).
REQ-026 During/after reset all valid and ready outputs SHALL be 0 until a new grant; in-flight transactions are abandoned.

Verification
REQ-027 m0 aw qos=2, m1 aw qos=5 same cycle, write 0xDEADBEEF to 0x10 -> m1 granted, s_aw_addr=m1 address, m0 aw_ready=0 until m1 b handshake.
REQ-028 Both qos=3 repeatedly for four writes -> grants alternate m1,m0,m1,m0.
REQ-029 s_w_ready asserted 2 cycles before s_aw_ready -> s_w_valid drops after W handshake, one AW, one W, FSM reaches W_RESP.
REQ-030 Concurrent m0 read of 0x04 and m1 write of 0x08 -> both proceed in parallel, r_data only to m0, b_resp only to m1.
REQ-031 rst_i pulsed during W_RESP -> next cycle all valids/readies 0, FSM W_IDLE, next tie grants m1.
REQ-032 Slave holds s_b_valid=1 with m0 b_ready=0 for 3 cycles -> grant held, m1 not served until m0 b handshake.
